// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC rotation sequencer: angle scale, arctangent table, FSM states.
package cordic_pkg;

  localparam int FULL_TURN       = 32768;
  localparam int PI_HALF         = 8192;
  localparam int CORDIC_GAIN_Q15 = 53961;
  localparam int MAX_ITERS       = 16;

  // round(atan(2^-i) * FULL_TURN / (2*pi))
  localparam logic [15:0] ATAN_TABLE [MAX_ITERS] = '{
    16'd4096, 16'd2418, 16'd1278, 16'd649,
    16'd326,  16'd163,  16'd81,   16'd41,
    16'd20,   16'd10,   16'd5,    16'd3,
    16'd1,    16'd1,    16'd0,    16'd0
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_input_standardizer.sv
// Quadrant pre-rotation: turns (x, y) clockwise by q*90 deg so the residual angle lies in [0, pi/2).
module cordic_input_standardizer
  import cordic_pkg::*;
(
  input  logic signed [15:0] i_x,
  input  logic signed [15:0] i_y,
  input  logic        [15:0] i_theta,
  output logic signed [16:0] o_x,
  output logic signed [16:0] o_y,
  output logic        [12:0] o_theta,
  output logic        [1:0]  o_quad
);

  logic        [14:0] w_theta_wrapped;
  logic signed [16:0] w_x;
  logic signed [16:0] w_y;

  assign w_theta_wrapped = 15'(i_theta % 16'(FULL_TURN));
  assign o_quad          = w_theta_wrapped[14:13];
  assign o_theta         = w_theta_wrapped[12:0];

  // One extra bit so that negating -32768 cannot wrap.
  assign w_x = {i_x[15], i_x};
  assign w_y = {i_y[15], i_y};

  always_comb begin
    o_x = w_x;
    o_y = w_y;
    case (o_quad)
      2'd1: begin o_x = w_y;  o_y = -w_x; end
      2'd2: begin o_x = -w_x; o_y = -w_y; end
      2'd3: begin o_x = -w_y; o_y = w_x;  end
      default: ;
    endcase
  end

endmodule

// File: rtl/cordic_rotate_sequencer.sv
// Iterative clockwise CORDIC rotation: one job per handshake, ITERS shift-add steps on a shared datapath.
//
// state | meaning
// IDLE  | in_ready high, waiting for a job
// ITER  | one micro-rotation per clock, r_iter = step index
// DONE  | result held on out_valid until the consumer takes it
module cordic_rotate_sequencer
  import cordic_pkg::*;
#(
  parameter int ITERS = 16,
  parameter int GUARD = 2,
  parameter int ZW    = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      x_in,
  input  logic signed [15:0]      y_in,
  input  logic        [15:0]      theta_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15+GUARD:0] x_out,
  output logic signed [15+GUARD:0] y_out,
  output logic        [1:0]       quad_out
);

  localparam int XW = 16 + GUARD;

  logic signed [16:0]   w_std_x;
  logic signed [16:0]   w_std_y;
  logic        [12:0]   w_std_theta;
  logic        [1:0]    w_std_quad;

  state_t               r_state;
  logic        [3:0]    r_iter;
  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic signed [ZW-1:0] r_z;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic signed [XW-1:0] r_x_out;
  logic signed [XW-1:0] r_y_out;
  logic        [1:0]    r_quad;

  logic signed [XW-1:0] w_x_shift;
  logic signed [XW-1:0] w_y_shift;
  logic signed [ZW-1:0] w_atan;
  logic                 w_dir;
  logic signed [XW-1:0] w_x_next;
  logic signed [XW-1:0] w_y_next;
  logic signed [ZW-1:0] w_z_next;

  cordic_input_standardizer u_std (
    .i_x     (x_in),
    .i_y     (y_in),
    .i_theta (theta_in),
    .o_x     (w_std_x),
    .o_y     (w_std_y),
    .o_theta (w_std_theta),
    .o_quad  (w_std_quad)
  );

  // Single micro-rotation stage; both updates use the pre-step x and y.
  assign w_x_shift = r_x >>> r_iter;
  assign w_y_shift = r_y >>> r_iter;
  assign w_atan    = $signed(ZW'(ATAN_TABLE[r_iter]));
  assign w_dir     = ~r_z[ZW-1];
  assign w_x_next  = w_dir ? (r_x + w_y_shift) : (r_x - w_y_shift);
  assign w_y_next  = w_dir ? (r_y - w_x_shift) : (r_y + w_x_shift);
  assign w_z_next  = w_dir ? (r_z - w_atan)    : (r_z + w_atan);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_iter      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_quad      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x        <= {{(XW-17){w_std_x[16]}}, w_std_x};
            r_y        <= {{(XW-17){w_std_y[16]}}, w_std_y};
            r_z        <= {{(ZW-13){1'b0}}, w_std_theta};
            r_quad     <= w_std_quad;
            r_iter     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ITER;
          end
        end
        ITER: begin
          r_x <= w_x_next;
          r_y <= w_y_next;
          r_z <= w_z_next;
          if (r_iter == 4'(ITERS - 1)) begin
            r_x_out     <= w_x_next;
            r_y_out     <= w_y_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_iter <= r_iter + 4'd1;
          end
        end
        DONE: begin
          // Return to IDLE only; the next job is taken on the following edge.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign x_out     = r_x_out;
  assign y_out     = r_y_out;
  assign quad_out  = r_quad;

endmodule

// File: tb/tb_cordic_rotate_sequencer.sv
// Directed bench for cordic_rotate_sequencer: reset, quadrants, corner, back-pressure, mid-job reset.
module tb_cordic_rotate_sequencer;

  localparam int  ITERS = 16;
  localparam int  GUARD = 2;
  localparam real K     = 1.6467602581;
  localparam real PI    = 3.14159265358979;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [15:0]       x_in = '0;
  logic signed [15:0]       y_in = '0;
  logic        [15:0]       theta_in = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [15+GUARD:0] x_out;
  logic signed [15+GUARD:0] y_out;
  logic        [1:0]        quad_out;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_rotate_sequencer #(.ITERS(ITERS), .GUARD(GUARD), .ZW(17)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .theta_in  (theta_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .quad_out  (quad_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input longint exp, input longint tol);
    longint d;
    d = obs - exp;
    if (d < 0) d = -d;
    n_tests++;
    assert ((d <= tol) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  // Gain-scaled clockwise rotation of (x, y) by theta (32768 = full turn).
  function automatic longint model_x(input int x, input int y, input int th);
    real a;
    a = real'(th % 32768) * 2.0 * PI / 32768.0;
    return longint'(K * (real'(x) * $cos(a) + real'(y) * $sin(a)));
  endfunction

  function automatic longint model_y(input int x, input int y, input int th);
    real a;
    a = real'(th % 32768) * 2.0 * PI / 32768.0;
    return longint'(K * (real'(y) * $cos(a) - real'(x) * $sin(a)));
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int x, input int y, input int th);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    x_in     = 16'(x);
    y_in     = 16'(y);
    theta_in = 16'(th);
    for (int k = 0; k < 60 && !ok; k++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", longint'(ok), 1);
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("out_timeout", longint'(out_valid), 1);
  endtask

  task automatic check_result(input string tag, input int x, input int y, input int th, input longint tol);
    chk({tag, "_quad"}, longint'(quad_out), longint'((th % 32768) / 8192));
    chk_tol({tag, "_x"}, longint'(x_out), model_x(x, y, th), tol);
    chk_tol({tag, "_y"}, longint'(y_out), model_y(x, y, th), tol);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("take_valid_low", longint'(out_valid), 0);
  endtask

  task automatic run_job(input string tag, input int x, input int y, input int th,
                         input longint tol, input int hold);
    int cyc;
    send(x, y, th);
    wait_out(cyc);
    repeat (hold) begin @(posedge clk); #1; end
    check_result(tag, x, y, th, tol);
    take_result();
  endtask

  initial begin
    int      cyc;
    longint  xo, yo;
    bit      ok;
    int      rx, ry, rt, nres;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready",  longint'(in_ready),  1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_x_out",     longint'(x_out),     0);
    chk("rst_y_out",     longint'(y_out),     0);
    chk("rst_quad",      longint'(quad_out),  0);

    // theta = 0 with exact latency check: 16384 * 1.64676 = 26981
    send(16384, 0, 0);
    chk("busy_in_ready", longint'(in_ready), 0);
    wait_out(cyc);
    chk("latency", longint'(cyc), ITERS);
    chk("t0_quad", longint'(quad_out), 0);
    chk_tol("t0_x", longint'(x_out), 26981, 16);
    chk_tol("t0_y", longint'(y_out), 0, 16);
    take_result();
    chk("after_take_ready", longint'(in_ready), 1);

    // pi/2 clockwise: (1/2, 0) -> (0, -gain/2)
    send(16384, 0, 8192);
    wait_out(cyc);
    chk("t90_quad", longint'(quad_out), 1);
    chk_tol("t90_x", longint'(x_out), 0, 16);
    chk_tol("t90_y", longint'(y_out), -26981, 16);
    take_result();

    // 32768 wraps to zero
    send(16384, 0, 32768);
    wait_out(cyc);
    chk("twrap_quad", longint'(quad_out), 0);
    chk_tol("twrap_x", longint'(x_out), 26981, 16);
    chk_tol("twrap_y", longint'(y_out), 0, 16);
    take_result();

    // Max corner at pi/4: sqrt2 * gain * 32767 = 76312, must not wrap into the sign bit
    send(32767, 32767, 4096);
    wait_out(cyc);
    chk("corner_quad", longint'(quad_out), 0);
    chk_tol("corner_x", longint'(x_out), 76312, 48);
    chk_tol("corner_y", longint'(y_out), 0, 48);
    chk("corner_sign", longint'(x_out[15+GUARD]), 0);
    take_result();

    // Other quadrants and the most negative input
    run_job("q2",   8192, -4096, 16384, 16, 0);
    run_job("q3",   10000, 5000, 24576, 16, 1);
    run_job("a22",  16384, 0,    2048,  16, 0);
    run_job("neg",  -32768, 0,   8292,  40, 2);

    // Back-pressure: result held 10 cycles, extra in_valid ignored
    send(16384, 0, 2048);
    wait_out(cyc);
    xo = longint'(x_out);
    yo = longint'(y_out);
    in_valid = 1'b1;
    x_in = 16'sd1000;
    y_in = 16'sd2000;
    theta_in = 16'd3000;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (x_out !== 18'(xo) || y_out !== 18'(yo) || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
    end
    chk("bp_stable", longint'(ok), 1);
    check_result("bp", 16384, 0, 2048, 16);
    in_valid = 1'b0;
    take_result();
    chk("bp_ready_next", longint'(in_ready), 1);
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
    end
    chk("bp_no_extra_job", longint'(ok), 1);

    // Reset during iteration 5 aborts the job without a result
    send(12000, 3000, 8692);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_in_ready",  longint'(in_ready),  1);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_x_out",     longint'(x_out),     0);
    chk("mid_rst_y_out",     longint'(y_out),     0);
    chk("mid_rst_quad",      longint'(quad_out),  0);
    ok = 1'b1;
    repeat (ITERS + 4) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("mid_rst_no_result", longint'(ok), 1);
    run_job("post_rst", 12000, 3000, 8692, 16, 0);

    // Short random run with random consumer delay
    nres = 0;
    for (int j = 0; j < 12; j++) begin
      rx = int'($urandom_range(16384)) - 8192;
      ry = int'($urandom_range(16384)) - 8192;
      rt = int'($urandom_range(65535));
      run_job("rand", rx, ry, rt, 16, int'($urandom_range(3)));
      nres++;
    end
    chk("rand_count", longint'(nres), 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
